// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: mnemonic codes plus the opcode and func fields
// used by both the single-cycle controller and the instruction encoder.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    ADD   = 5'd0,
    SUB   = 5'd1,
    AND   = 5'd2,
    OR    = 5'd3,
    XOR   = 5'd4,
    NOR   = 5'd5,
    SLT   = 5'd6,
    SLTU  = 5'd7,
    SLL   = 5'd8,
    SRL   = 5'd9,
    SRA   = 5'd10,
    JR    = 5'd11,
    LW    = 5'd12,
    SW    = 5'd13,
    ADDI  = 5'd14,
    ADDIU = 5'd15,
    SLTI  = 5'd16,
    ORI   = 5'd17,
    BEQ   = 5'd18,
    BNE   = 5'd19,
    J     = 5'd20,
    JAL   = 5'd21,
    LUI   = 5'd22,
    RSVD  = 5'd23
  } mnem_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, shamt, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder from a symbolic instruction to its 32-bit MIPS word;
// unused fields are forced to zero so the word matches canonical assembler output.
module instr_encode
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (mnem)
      ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
      OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
      XOR:   word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      NOR:   word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      SLTU:  word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
      SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      SRL:   word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      SRA:   word = r_word(5'd0, rt, rd, shamt, FN_SRA);
      JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      LW:    word = i_word(OP_LW, rs, rt, imm);
      SW:    word = i_word(OP_SW, rs, rt, imm);
      ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
      ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
      SLTI:  word = i_word(OP_SLTI, rs, rt, imm);
      ORI:   word = i_word(OP_ORI, rs, rt, imm);
      BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
      BNE:   word = i_word(OP_BNE, rs, rt, imm);
      LUI:   word = i_word(OP_LUI, 5'd0, rt, imm);
      J:     word = {OP_J, target};
      JAL:   word = {OP_JAL, target};
      // Reserved code 23 and 24..31 have no encoding.
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Accepts symbolic instructions, encodes them and writes the words sequentially
// into instruction memory, one instruction every two cycles.
module instr_encode_loader
  import mips_isa_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(IMEM_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       enc_word;
  logic              enc_legal;

  instr_encode u_encode (
    .mnem   (mnem),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .imm    (imm),
    .target (target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // Clear wins over everything, including a pending write and a same-cycle request.
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (enc_legal) begin
              we_d    = 1'b1;
              addr_d  = count_q[ADDR_W-1:0];
              wdata_d = enc_word;
              state_d = S_WRITE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_WRITE: begin
          count_d = count_q + 1'b1;
          state_d = (count_d == DEPTH_C) ? S_FULL : S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready    = reset_n && (state_q == S_IDLE);
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign err_illegal = err_q;

endmodule
